// File: rtl/arm_uart_pkg.sv
// rtl/arm_uart_pkg.sv - shared baud table, frame constants and FSM encodings for the arm UART link
package arm_uart_pkg;

  localparam logic [7:0] HDR0        = 8'h55;
  localparam logic [7:0] HDR1        = 8'hAA;
  localparam int         FRAME_BYTES = 10;
  localparam int         DIV_W       = 16;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [1:0] {F_HUNT, F_HDR2, F_BODY, F_CHECK} frame_state_t;

  // Rounded 16x divisor; at 50 MHz this gives 325/162/80/53/26.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input int baud);
    return DIV_W'((clk_hz + 8 * baud) / (16 * baud) - 1);
  endfunction

  function automatic int byte_lsb(input int k, input bit msb_first);
    return msb_first ? (FRAME_BYTES - 1 - k) * 8 : k * 8;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - synchroniser, 16x sample tick and byte FSM with 3-sample majority vote
module uart_byte_rx
  import arm_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic [2:0] i_baud_set,
  output logic [7:0] o_byte,
  output logic       o_done,
  output logic       o_stop_err,
  output logic       o_busy,
  output logic       o_tick
);

  localparam logic [DIV_W-1:0] DIV_0 = baud_div(CLK_HZ, 9600);
  localparam logic [DIV_W-1:0] DIV_1 = baud_div(CLK_HZ, 19200);
  localparam logic [DIV_W-1:0] DIV_2 = baud_div(CLK_HZ, 38400);
  localparam logic [DIV_W-1:0] DIV_3 = baud_div(CLK_HZ, 57600);
  localparam logic [DIV_W-1:0] DIV_4 = baud_div(CLK_HZ, 115200);

  byte_state_t      r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_prev;
  logic [DIV_W-1:0] r_div, r_tick_cnt, w_div_sel;
  logic [3:0]       r_smp;
  logic [2:0]       r_bit;
  logic [1:0]       r_votes;
  logic [7:0]       r_shift;
  logic             r_done, r_stop_err;
  logic             w_line, w_fall, w_tick, w_maj, w_done_nxt, w_err_nxt;

  assign w_line = r_sync[1];
  assign w_fall = r_prev & ~w_line;
  assign w_tick = (r_tick_cnt >= r_div);
  // Samples 7 and 8 are stored; sample 9 is the live line value.
  assign w_maj  = (r_votes[1] & r_votes[0]) | (r_votes[1] & w_line) | (r_votes[0] & w_line);

  always_comb begin
    case (i_baud_set)
      3'd0:    w_div_sel = DIV_0;
      3'd1:    w_div_sel = DIV_1;
      3'd2:    w_div_sel = DIV_2;
      3'd3:    w_div_sel = DIV_3;
      default: w_div_sel = DIV_4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      B_IDLE:  if (w_fall) w_state_nxt = B_START;
      B_START: begin
        if (w_tick && r_smp == 4'd9 && w_maj)  w_state_nxt = B_IDLE;
        else if (w_tick && r_smp == 4'd15)     w_state_nxt = B_DATA;
      end
      B_DATA:  if (w_tick && r_smp == 4'd15 && r_bit == 3'd7) w_state_nxt = B_STOP;
      B_STOP:  begin
        if (w_tick && r_smp == 4'd9) begin
          w_state_nxt = B_IDLE;
          w_done_nxt  = w_maj;
          w_err_nxt   = ~w_maj;
        end
      end
      default: w_state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= B_IDLE;
      r_sync     <= 2'b11;
      r_prev     <= 1'b1;
      r_div      <= DIV_4;
      r_tick_cnt <= '0;
      r_smp      <= '0;
      r_bit      <= '0;
      r_votes    <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_rx};
      r_prev     <= w_line;
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_stop_err <= w_err_nxt;
      if (r_state == B_IDLE) r_div <= w_div_sel;
      if (r_state == B_IDLE && w_fall) begin
        r_tick_cnt <= '0;
        r_smp      <= '0;
        r_bit      <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= '0;
        r_smp      <= r_smp + 4'd1;
        if (r_smp == 4'd7 || r_smp == 4'd8) r_votes <= {r_votes[0], w_line};
        if (r_state == B_DATA && r_smp == 4'd9)  r_shift <= {w_maj, r_shift[7:1]};
        if (r_state == B_DATA && r_smp == 4'd15) r_bit <= r_bit + 3'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + DIV_W'(1);
      end
    end
  end

  assign o_byte     = r_shift;
  assign o_done     = r_done;
  assign o_stop_err = r_stop_err;
  assign o_busy     = (r_state != B_IDLE);
  assign o_tick     = w_tick;

endmodule

// File: rtl/arm_cmd_uart_rx.sv
// rtl/arm_cmd_uart_rx.sv - arm command frame receiver: header hunt, checksum, timeout, output registers
module arm_cmd_uart_rx
  import arm_uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DATA_WIDTH   = 80,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  uart_rx,
  input  logic [2:0]            Baud_Set_in,
  output logic [DATA_WIDTH-1:0] Frame_Data,
  output logic                  Frame_Valid,
  output logic [7:0]            out_id,
  output logic                  out_cmd,
  output logic                  Frame_Err,
  output logic                  Rx_Done,
  output logic                  uart_state
);

  localparam int TO_TICKS = TIMEOUT_BITS * 16;
  localparam int ID_LSB   = byte_lsb(2, MSB_FIRST);
  localparam int CMD_LSB  = byte_lsb(3, MSB_FIRST);

  logic [7:0] w_byte;
  logic       w_done, w_stop_err, w_busy, w_tick;

  uart_byte_rx #(.CLK_HZ(CLK_HZ)) u_byte_rx (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_rx       (uart_rx),
    .i_baud_set (Baud_Set_in),
    .o_byte     (w_byte),
    .o_done     (w_done),
    .o_stop_err (w_stop_err),
    .o_busy     (w_busy),
    .o_tick     (w_tick)
  );

  frame_state_t          r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt, w_idx;
  logic [7:0]            r_sum, w_sum_nxt;
  logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt, r_frame;
  logic [15:0]           r_to_cnt, w_to_nxt;
  logic [7:0]            r_id;
  logic                  r_cmd, r_valid, r_err;
  logic                  w_store, w_valid_nxt, w_err_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_acc_nxt   = r_acc;
    w_to_nxt    = '0;
    w_store     = 1'b0;
    w_idx       = '0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = w_stop_err;
    case (r_state)
      F_HUNT: begin
        if (w_done && w_byte == HDR0) begin
          w_store     = 1'b1;
          w_state_nxt = F_HDR2;
        end
      end
      F_HDR2: begin
        if (w_done) begin
          if (w_byte == HDR1) begin
            w_store     = 1'b1;
            w_idx       = 4'd1;
            w_cnt_nxt   = 4'd2;
            w_sum_nxt   = '0;
            w_state_nxt = F_BODY;
          end else if (w_byte == HDR0) begin
            w_store = 1'b1;
          end else begin
            w_state_nxt = F_HUNT;
          end
        end
      end
      F_BODY: begin
        if (w_done) begin
          w_store = 1'b1;
          w_idx   = r_cnt;
          if (r_cnt == 4'd9) begin
            w_valid_nxt = ((~r_sum) == w_byte);
            w_err_nxt   = ((~r_sum) != w_byte);
            w_state_nxt = F_CHECK;
          end else begin
            w_sum_nxt = r_sum + w_byte;
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = F_HUNT;
    endcase

    if (w_store) begin
      for (int k = 0; k < FRAME_BYTES; k++) begin
        if (w_idx == 4'(k)) w_acc_nxt[byte_lsb(k, MSB_FIRST) +: 8] = w_byte;
      end
    end

    // Inter-byte timeout counts sample ticks and restarts on every accepted byte.
    if ((r_state == F_HDR2 || r_state == F_BODY) && !w_done) begin
      w_to_nxt = r_to_cnt;
      if (w_tick) begin
        if (r_to_cnt == 16'(TO_TICKS - 1)) begin
          w_to_nxt    = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = F_HUNT;
        end else begin
          w_to_nxt = r_to_cnt + 16'd1;
        end
      end
    end

    if (w_stop_err) w_state_nxt = F_HUNT;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= F_HUNT;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_acc    <= '0;
      r_to_cnt <= '0;
      r_frame  <= '0;
      r_id     <= '0;
      r_cmd    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sum    <= w_sum_nxt;
      r_acc    <= w_acc_nxt;
      r_to_cnt <= w_to_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      if (w_valid_nxt) begin
        r_frame <= w_acc_nxt;
        r_id    <= w_acc_nxt[ID_LSB +: 8];
        r_cmd   <= w_acc_nxt[CMD_LSB];
      end
    end
  end

  assign Frame_Data  = r_frame;
  assign Frame_Valid = r_valid;
  assign out_id      = r_id;
  assign out_cmd     = r_cmd;
  assign Frame_Err   = r_err;
  assign Rx_Done     = w_done;
  assign uart_state  = w_busy | (r_state != F_HUNT);

endmodule

// File: tb/tb_arm_cmd_uart_rx.sv
// tb/tb_arm_cmd_uart_rx.sv - directed bench for arm_cmd_uart_rx at a scaled clock
module tb_arm_cmd_uart_rx;

  localparam logic [79:0] FRAME_A   = 80'h55AA02010000000000FC;
  localparam logic [79:0] FRAME_B   = 80'h55AA09000000000000F6;
  localparam logic [79:0] FRAME_BAD = 80'h55AA02010000000000FD;

  logic        clk = 1'b0;
  logic        Rst;
  logic        uart_rx;
  logic [2:0]  Baud_Set_in;
  logic [79:0] Frame_Data;
  logic        Frame_Valid;
  logic [7:0]  out_id;
  logic        out_cmd;
  logic        Frame_Err;
  logic        Rx_Done;
  logic        uart_state;

  // 3.6864 MHz gives 32 clocks/bit at setting 4 and 384 clocks/bit at setting 0.
  arm_cmd_uart_rx #(.CLK_HZ(3_686_400)) dut (
    .Clk         (clk),
    .Rst         (Rst),
    .uart_rx     (uart_rx),
    .Baud_Set_in (Baud_Set_in),
    .Frame_Data  (Frame_Data),
    .Frame_Valid (Frame_Valid),
    .out_id      (out_id),
    .out_cmd     (out_cmd),
    .Frame_Err   (Frame_Err),
    .Rx_Done     (Rx_Done),
    .uart_state  (uart_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bit_clks = 32;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, done_cnt = 0, both_cnt = 0;
  int last_done = 0, valid_lat = -1;
  int base_v, base_e, base_d;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (Rx_Done) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
    if (Frame_Valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_lat <= cyc - last_done;
    end
    if (Frame_Err) err_cnt <= err_cnt + 1;
    if (Frame_Valid && Frame_Err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_v = valid_cnt;
    base_e = err_cnt;
    base_d = done_cnt;
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * bit_clks) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [79:0] f, input int n);
    logic [79:0] t;
    t = f;
    for (int k = 0; k < n; k++) begin
      send_byte(t[79:72], 1'b1);
      t = t << 8;
    end
  endtask

  initial begin
    Rst = 1'b1;
    uart_rx = 1'b1;
    Baud_Set_in = 3'd4;
    repeat (4) @(negedge clk);
    check("rst_data", Frame_Data, 80'd0);
    check("rst_valid", 80'(Frame_Valid), 80'd0);
    check("rst_id", 80'(out_id), 80'd0);
    check("rst_cmd", 80'(out_cmd), 80'd0);
    check("rst_err", 80'(Frame_Err), 80'd0);
    check("rst_done", 80'(Rx_Done), 80'd0);
    check("rst_state", 80'(uart_state), 80'd0);
    Rst = 1'b0;
    idle_bits(2);

    snap();
    send_frame(FRAME_A, 10);
    idle_bits(2);
    check_int("a_valid", valid_cnt - base_v, 1);
    check_int("a_err", err_cnt - base_e, 0);
    check_int("a_done", done_cnt - base_d, 10);
    check_int("a_latency", valid_lat, 1);
    check("a_data", Frame_Data, FRAME_A);
    check("a_id", 80'(out_id), 80'h02);
    check("a_cmd", 80'(out_cmd), 80'd1);
    check("a_state", 80'(uart_state), 80'd0);

    Baud_Set_in = 3'd0;
    bit_clks = 384;
    idle_bits(1);
    snap();
    send_frame(FRAME_B, 10);
    idle_bits(2);
    check_int("b_valid", valid_cnt - base_v, 1);
    check_int("b_err", err_cnt - base_e, 0);
    check("b_id", 80'(out_id), 80'h09);
    check("b_cmd", 80'(out_cmd), 80'd0);
    check("b_data", Frame_Data, FRAME_B);

    Baud_Set_in = 3'd4;
    bit_clks = 32;
    idle_bits(2);
    snap();
    send_frame(FRAME_BAD, 10);
    idle_bits(2);
    check_int("bad_err", err_cnt - base_e, 1);
    check_int("bad_valid", valid_cnt - base_v, 0);
    check("bad_keep_data", Frame_Data, FRAME_B);
    check("bad_keep_id", 80'(out_id), 80'h09);

    snap();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    check("glitch_busy", 80'(uart_state), 80'd1);
    idle_bits(2);
    check_int("glitch_done", done_cnt - base_d, 0);
    check_int("glitch_err", err_cnt - base_e, 0);
    check("glitch_state", 80'(uart_state), 80'd0);

    snap();
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b0);
    idle_bits(2);
    check_int("stop_err", err_cnt - base_e, 1);
    check_int("stop_valid", valid_cnt - base_v, 0);
    check("stop_state", 80'(uart_state), 80'd0);
    snap();
    send_frame(FRAME_A, 10);
    idle_bits(2);
    check_int("stop_next_valid", valid_cnt - base_v, 1);
    check_int("stop_next_err", err_cnt - base_e, 0);
    check("stop_next_data", Frame_Data, FRAME_A);

    snap();
    send_frame(FRAME_A, 5);
    idle_bits(30);
    check_int("to_early_err", err_cnt - base_e, 0);
    check("to_early_state", 80'(uart_state), 80'd1);
    idle_bits(20);
    check_int("to_err", err_cnt - base_e, 1);
    check_int("to_valid", valid_cnt - base_v, 0);
    check("to_state", 80'(uart_state), 80'd0);

    snap();
    send_frame(FRAME_A, 10);
    send_frame(FRAME_B, 10);
    idle_bits(2);
    check_int("b2b_valid", valid_cnt - base_v, 2);
    check_int("b2b_done", done_cnt - base_d, 20);
    check_int("b2b_err", err_cnt - base_e, 0);
    check("b2b_data", Frame_Data, FRAME_B);

    send_frame(FRAME_A, 3);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    check("mid_rst_data", Frame_Data, 80'd0);
    check("mid_rst_id", 80'(out_id), 80'd0);
    check("mid_rst_valid", 80'(Frame_Valid), 80'd0);
    check("mid_rst_err", 80'(Frame_Err), 80'd0);
    check("mid_rst_state", 80'(uart_state), 80'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    idle_bits(2);
    check("post_rst_state", 80'(uart_state), 80'd0);
    snap();
    send_frame(FRAME_B, 10);
    idle_bits(2);
    check_int("post_rst_valid", valid_cnt - base_v, 1);
    check("post_rst_id", 80'(out_id), 80'h09);

    check_int("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
